// File: rtl/vga_timing_gen.sv
// vga_timing_gen: configurable VGA raster timing generator.
// Divides CLK into a one-cycle pixel strobe and runs the horizontal and
// vertical raster counters, producing sync, blanking and line/frame strobes.
//
// Ports:
//   CLK        in   system clock
//   RESET_N    in   synchronous active-low reset (priority over en)
//   en         in   run enable, 0 freezes all timing state
//   p_tick     out  one-cycle pixel strobe
//   pixel_x    out  horizontal counter 0..H_TOTAL-1
//   pixel_y    out  vertical counter 0..V_TOTAL-1
//   hsync      out  horizontal sync, active level HS_POL
//   vsync      out  vertical sync, active level VS_POL
//   video_on   out  inside the active area
//   line_end   out  last pixel strobe of a line
//   frame_end  out  last pixel strobe of a frame
//   frame_cnt  out  frame counter
//
// Build option: define VGA_FRAME_CNT_EN to build the frame counter;
// without it frame_cnt is tied to zero.
//
// All outputs are registered. The sync/blank decodes are taken from the
// next-state coordinates so they line up with pixel_x/pixel_y.

module vga_timing_gen #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned DIV     = 4,
    parameter int unsigned H_ACT   = 640,
    parameter int unsigned H_FP    = 16,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_BP    = 48,
    parameter int unsigned V_ACT   = 480,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_BP    = 33,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0,
    parameter int unsigned FRAME_W = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               en,
    output logic               p_tick,
    output logic [CNT_W-1:0]   pixel_x,
    output logic [CNT_W-1:0]   pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_end,
    output logic               frame_end,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_M1 = DIV_W'(DIV - 1);

    localparam logic [CNT_W-1:0] H_M1     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_M1     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             von_q, von_d;
    logic             le_q, le_d;
    logic             fe_q, fe_d;
    logic             adv;

    // Divider. The counters advance on the edge that closes a visible
    // p_tick cycle. If en dropped while a tick was due, the divider parks
    // at DIV-1 and re-issues that tick on resume, so no pixel is lost.
    always_comb begin
        div_d = div_q;
        adv   = 1'b0;
        if (en) begin
            if (div_q == DIV_M1) begin
                if (tick_q) begin
                    div_d = '0;
                    adv   = 1'b1;
                end
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    assign tick_d = en && (div_d == DIV_M1);

    // Raster counters.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (adv) begin
            if (x_q == H_M1) begin
                x_d = '0;
                if (y_q == V_M1) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CNT_W'(1);
                end
            end else begin
                x_d = x_q + CNT_W'(1);
            end
        end
    end

    // Decodes of the next coordinates, registered alongside them.
    always_comb begin
        hs_d  = ~HS_POL;
        vs_d  = ~VS_POL;
        if ((x_d >= HS_START) && (x_d <= HS_END)) begin
            hs_d = HS_POL;
        end
        if ((y_d >= VS_START) && (y_d <= VS_END)) begin
            vs_d = VS_POL;
        end
        von_d = (x_d < H_ACT_C) && (y_d < V_ACT_C);
        le_d  = tick_d && (x_d == H_M1);
        fe_d  = le_d && (y_d == V_M1);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            von_q  <= 1'b1;
            le_q   <= 1'b0;
            fe_q   <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            von_q  <= von_d;
            le_q   <= le_d;
            fe_q   <= fe_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_W-1:0] fc_q, fc_d;
    logic               frame_wrap;

    // Steps on the same edge as the wrap to (0,0).
    assign frame_wrap = adv && (x_q == H_M1) && (y_q == V_M1);

    always_comb begin
        fc_d = fc_q;
        if (frame_wrap) begin
            fc_d = fc_q + FRAME_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            fc_q <= '0;
        end else begin
            fc_q <= fc_d;
        end
    end

    assign frame_cnt = fc_q;
`else
    assign frame_cnt = '0;
`endif

    assign p_tick    = tick_q;
    assign pixel_x   = x_q;
    assign pixel_y   = y_q;
    assign hsync     = hs_q;
    assign vsync     = vs_q;
    assign video_on  = von_q;
    assign line_end  = le_q;
    assign frame_end = fe_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// Instance a: small mode, DIV=2. Instance b: same mode, DIV=1, HS_POL=1.

module tb_vga_timing_gen;

    logic        clk;
    logic        rst_n;
    logic        en;

    logic        a_tick, a_hs, a_vs, a_von, a_le, a_fe;
    logic [10:0] a_x, a_y;
    logic [1:0]  a_fc;

    logic        b_tick, b_hs, b_vs, b_von, b_le, b_fe;
    logic [10:0] b_x, b_y;
    logic [1:0]  b_fc;

    int errs;
    int checks;

    vga_timing_gen #(
        .CNT_W(11), .DIV(2),
        .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_W(2)
    ) u_a (
        .CLK(clk), .RESET_N(rst_n), .en(en),
        .p_tick(a_tick), .pixel_x(a_x), .pixel_y(a_y),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
        .line_end(a_le), .frame_end(a_fe), .frame_cnt(a_fc)
    );

    vga_timing_gen #(
        .CNT_W(11), .DIV(1),
        .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .FRAME_W(2)
    ) u_b (
        .CLK(clk), .RESET_N(rst_n), .en(en),
        .p_tick(b_tick), .pixel_x(b_x), .pixel_y(b_y),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
        .line_end(b_le), .frame_end(b_fe), .frame_cnt(b_fc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Expected flags {p_tick, hsync, vsync, video_on, line_end, frame_end}
    // of instance a at coordinate (x,y) with strobe p.
    function automatic logic [5:0] flags_a(int x, int y, bit p);
        bit le;
        le = p && (x == 7);
        return {p, !(x == 5 || x == 6), !(y == 4), (x < 4 && y < 3),
                le, le && (y == 5)};
    endfunction

    initial begin
        int ex, ey, ec, nle, nfe;
        bit ep;
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        en     = 1'b1;

        // Reset state.
        do_reset();
        chk("rst_xy", {a_y[7:0], a_x[7:0]}, 32'h0);
        chk("rst_flags", {26'd0, a_tick, a_hs, a_vs, a_von, a_le, a_fe},
            {26'd0, 6'b011100});
        chk("rst_fc", {30'd0, a_fc}, 32'd0);
        chk("rst_b_hs", {31'd0, b_hs}, 32'd0);
        chk("rst_b_tick", {31'd0, b_tick}, 32'd0);

        // Free run: five frames plus a little more.
        nle = 0;
        nfe = 0;
        for (int k = 0; k < 490; k++) begin
            step();
            ex = ((k + 1) / 2) % 8;
            ey = ((k + 1) / 16) % 6;
            ep = (k % 2 == 0);
            chk("a_xy", {a_y[15:0], a_x[15:0]}, {ey[15:0], ex[15:0]});
            chk("a_flags", {26'd0, a_tick, a_hs, a_vs, a_von, a_le, a_fe},
                {26'd0, flags_a(ex, ey, ep)});
`ifdef VGA_FRAME_CNT_EN
            ec = ((k + 1) / 96) % 4;
`else
            ec = 0;
`endif
            chk("a_fc", {30'd0, a_fc}, ec);
            if (k < 96) begin
                nle += int'(a_le);
                nfe += int'(a_fe);
                if (a_fe) begin
                    chk("fe_at", {a_y[15:0], a_x[15:0]}, {16'd5, 16'd7});
                end
            end
            ex = k % 8;
            ey = (k / 8) % 6;
            chk("b_xy", {b_y[15:0], b_x[15:0]}, {ey[15:0], ex[15:0]});
            chk("b_tick", {31'd0, b_tick}, 32'd1);
            chk("b_hs", {31'd0, b_hs}, {31'd0, (ex == 5 || ex == 6)});
        end
        chk("le_count", nle, 6);
        chk("fe_count", nfe, 1);

        // Freeze mid-line at x=3.
        do_reset();
        for (int k = 0; k < 7; k++) step();
        chk("pre_frz", {a_tick, a_y[7:0], a_x[7:0]}, {1'b1, 8'd0, 8'd3});
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("frz_a", {26'd0, a_tick, a_hs, a_vs, a_von, a_le, a_fe},
                {26'd0, 6'b011100});
            chk("frz_ax", {16'd0, a_x[15:0]}, 32'd3);
            chk("frz_bx", {16'd0, b_x[15:0]}, 32'd6);
        end
        en = 1'b1;
        step();
        chk("res0", {a_tick, a_x[7:0], b_tick, b_x[7:0]},
            {1'b1, 8'd3, 1'b1, 8'd6});
        step();
        chk("res1", {a_tick, a_x[7:0], b_tick, b_x[7:0]},
            {1'b0, 8'd4, 1'b1, 8'd7});
        step();
        chk("res2", {a_tick, a_x[7:0]}, {1'b1, 8'd4});
        step();
        chk("res3", {a_tick, a_x[7:0]}, {1'b0, 8'd5});

        // Reset pulse at (6,4).
        do_reset();
        for (int k = 0; k < 76; k++) step();
        chk("pre_rst", {a_hs, a_vs, a_y[7:0], a_x[7:0]},
            {1'b0, 1'b0, 8'd4, 8'd6});
        rst_n = 1'b0;
        step();
        chk("mid_rst", {a_tick, a_hs, a_vs, a_von, a_y[7:0], a_x[7:0]},
            {4'b0111, 8'd0, 8'd0});
        chk("mid_rst_b", {b_tick, b_hs, b_x[7:0]}, {1'b0, 1'b0, 8'd0});
        chk("mid_rst_fc", {30'd0, a_fc}, 32'd0);
        rst_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
